video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
- REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
- REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch in pixels.
- REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
- REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch in lines.
- REQ-005 Parameter PIX_DIV, default 4: clk100 cycles per pixel; legal values are 1 and above.
- REQ-006 Parameters HS_POL / VS_POL, default 0 / 0: asserted level of hsync / vsync.
- REQ-007 Parameter LINE_LEAD, default 16: pixels before line end at which nextLine fires; legal range 0..H_TOTAL-1.
- REQ-008 Parameter CW, default 10: width of the Pixel and Line counters; must hold H_TOTAL-1 and V_TOTAL-1.
- REQ-009 clk100, input, 1 bit: sole clock, rising edge.
- REQ-010 rst, input, 1 bit: reset, asynchronous, active-high.
- REQ-011 en, input, 1 bit: run enable; low freezes all timing.
- REQ-012 hsync, output, 1 bit: horizontal sync.
- REQ-013 vsync, output, 1 bit: vertical sync.
- REQ-014 Pixel, output, CW bits: current horizontal count.
- REQ-015 Line, output, CW bits: current vertical count.
- REQ-016 active, output, 1 bit: high inside the visible region.
- REQ-017 pxTick, output, 1 bit: pixel-rate strobe.
- REQ-018 nextLine, output, 1 bit: one-cycle pulse requesting a render of the next line.
- REQ-019 nextFrame, output, 1 bit: one-cycle pipeline frame-restart pulse.
- REQ-020 bank, output, 1 bit: line-buffer ping-pong select for the render side.

Function
- REQ-021 Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; defaults give 800 / 525.
- REQ-022 Divider:
  - counts 0..PIX_DIV-1 while en=1;
  - pxTick is high for exactly one clk100 cycle, the cycle in which the divider equals PIX_DIV-1;
  - with PIX_DIV=1, pxTick is high every cycle en=1.
- REQ-023 Counters:
  - on every rising edge with pxTick=1, Pixel increments, wrapping H_TOTAL-1 to 0;
  - Line increments on each Pixel wrap, wrapping V_TOTAL-1 to 0.
- REQ-024 Registered outputs (hsync, vsync, active, nextLine, nextFrame, bank) update on the same edge as the counters, decoded from the new counter values; there is zero skew between any output and Pixel/Line.
- REQ-025 hsync = HS_POL iff Pixel is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise hsync = ~HS_POL.
- REQ-026 vsync = VS_POL iff Line is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise vsync = ~VS_POL.
- REQ-027 active = 1 iff Pixel < H_ACTIVE and Line < V_ACTIVE.
- REQ-028 nextLine:
  - pulses for one cycle when the new Pixel = H_TOTAL-1-LINE_LEAD;
  - only when the new Line is V_TOTAL-1 or in 0..V_ACTIVE-2, i.e. one pulse precedes each visible line;
  - gives exactly V_ACTIVE pulses per frame.
- REQ-029 nextFrame:
  - pulses for one cycle when the counters advance to Pixel=0, Line=V_ACTIVE (start of vertical blank);
  - gives exactly one pulse per frame.
- REQ-030 bank toggles on every nextLine pulse and is forced to 0 on nextFrame; the first visible line of each frame therefore renders with bank=1.
- REQ-031 en=0:
  - divider, counters and all outputs hold their values;
  - pxTick, nextLine and nextFrame are 0;
  - on return to en=1, counting resumes from the held divider value.
- REQ-032 Simultaneous events: a Pixel wrap and a Line wrap on the same edge land on Pixel=0, Line=0. nextLine and nextFrame never coincide.

Reset
- REQ-033 rst=1 immediately (asynchronously) forces the following values:
  - divider, Pixel and Line to 0;
  - hsync to ~HS_POL and vsync to ~VS_POL;
  - active, pxTick, nextLine, nextFrame and bank to 0.
- REQ-034 After rst deasserts, the first pxTick occurs in the PIX_DIV-th clk100 cycle; active becomes 1 on that edge (Pixel=1, Line=0).
- REQ-035 rst asserted mid-frame aborts the frame with no residual pulse; the sequence restarts exactly as REQ-034 describes.

Verification
- REQ-036 Defaults, release rst at cycle 0 -> pxTick high in cycle 3, period 4 cycles; Pixel=1 after the edge ending cycle 3.
- REQ-037 Defaults, one line -> hsync low for exactly 96 pixels (384 clocks) starting at Pixel=656; line period 3200 clocks.
- REQ-038 Defaults, one frame -> vsync low only at Lines 490-491; exactly one nextFrame per 1,680,000 clocks, at Line=480, Pixel=0.
- REQ-039 Defaults, one frame -> 480 nextLine pulses, the first at Line=524, Pixel=783; bank reads 1 throughout visible line 0 and 0 throughout line 1.
- REQ-040 en low for 100 cycles at Pixel=300 -> Pixel, Line and syncs hold; no pulses occur; on resume the next increment goes to 301.
- REQ-041 rst pulsed at Line=200 -> outputs hold reset values while rst=1, with no clock edge required; after release the REQ-034 sequence repeats.
- REQ-042 PIX_DIV=1 with H_ACTIVE=4, H_FP=H_SYNC=H_BP=1 and LINE_LEAD=0 -> pxTick is constant 1, Pixel cycles 0..6, and nextLine fires at Pixel=6.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-rate divider, Pixel/Line counters and
// registered sync/active/render-request outputs aligned to the counters.
module video_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   PIX_DIV   = 4,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   LINE_LEAD = 16,
    parameter int   CW        = 10
) (
    input  logic          clk100,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] Pixel,
    output logic [CW-1:0] Line,
    output logic          active,
    output logic          pxTick,
    output logic          nextLine,
    output logic          nextFrame,
    output logic          bank
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST    = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS       = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS       = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST    = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST     = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST     = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] NL_PIX      = CW'(H_TOTAL - 1 - LINE_LEAD);
    localparam bit            MULTI_LINE  = (V_ACTIVE >= 2);
    localparam logic [CW-1:0] NL_LAST_VIS = CW'(MULTI_LINE ? V_ACTIVE - 2 : 0);

    logic [DW-1:0] div;
    logic [CW-1:0] pix_nxt;
    logic [CW-1:0] line_nxt;
    logic          tick;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          act_nxt;
    logic          nl_nxt;
    logic          nf_nxt;
    logic          nl_q;
    logic          nf_q;

    assign tick   = en && !rst && (div == DIV_LAST);
    assign pxTick = tick;

    // Pulse registers hold while frozen; gating keeps them invisible until en returns.
    assign nextLine  = nl_q && en;
    assign nextFrame = nf_q && en;

    always_comb begin
        pix_nxt  = Pixel + CW'(1);
        line_nxt = Line;
        if (Pixel == H_LAST) begin
            pix_nxt  = '0;
            line_nxt = (Line == V_LAST) ? '0 : Line + CW'(1);
        end
        hs_nxt  = (pix_nxt >= HS_FIRST && pix_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
        vs_nxt  = (line_nxt >= VS_FIRST && line_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
        act_nxt = (pix_nxt < H_VIS) && (line_nxt < V_VIS);
        // One request per visible line, issued during the preceding line.
        nl_nxt  = (pix_nxt == NL_PIX) &&
                  ((line_nxt == V_LAST) || (MULTI_LINE && line_nxt <= NL_LAST_VIS));
        nf_nxt  = (pix_nxt == '0) && (line_nxt == V_VIS);
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + DW'(1);
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            Pixel  <= '0;
            Line   <= '0;
            hsync  <= ~HS_POL;
            vsync  <= ~VS_POL;
            active <= 1'b0;
            nl_q   <= 1'b0;
            nf_q   <= 1'b0;
            bank   <= 1'b0;
        end else if (en) begin
            nl_q <= 1'b0;
            nf_q <= 1'b0;
            if (tick) begin
                Pixel  <= pix_nxt;
                Line   <= line_nxt;
                hsync  <= hs_nxt;
                vsync  <= vs_nxt;
                active <= act_nxt;
                nl_q   <= nl_nxt;
                nf_q   <= nf_nxt;
                if (nf_nxt) begin
                    bank <= 1'b0;
                end else if (nl_nxt) begin
                    bank <= ~bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-raster instance checked by vector table and
// a tick-count reference model under random enable, plus a PIX_DIV=1 instance.
module tb_video_timing_gen;
    localparam int   AHA = 8, AHF = 2, AHS = 3, AHB = 2;
    localparam int   AVA = 6, AVF = 1, AVS = 2, AVB = 1;
    localparam int   APD = 3, ALL = 2, ACW = 6;
    localparam logic AHP = 1'b0, AVP = 1'b1;
    localparam int   AHT = AHA + AHF + AHS + AHB;
    localparam int   AVT = AVA + AVF + AVS + AVB;

    logic clk100 = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b0;

    logic           a_hs, a_vs, a_act, a_tick, a_nl, a_nf, a_bank;
    logic [ACW-1:0] a_pix, a_line;
    logic           b_hs, b_vs, b_act, b_tick, b_nl, b_nf, b_bank;
    logic [3:0]     b_pix, b_line;

    int checks = 0;
    int passed = 0;
    bit model_on = 1'b0;

    video_timing_gen #(
        .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
        .PIX_DIV(APD), .HS_POL(AHP), .VS_POL(AVP), .LINE_LEAD(ALL), .CW(ACW)
    ) dut_a (
        .clk100(clk100), .rst(rst), .en(en), .hsync(a_hs), .vsync(a_vs),
        .Pixel(a_pix), .Line(a_line), .active(a_act), .pxTick(a_tick),
        .nextLine(a_nl), .nextFrame(a_nf), .bank(a_bank)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .LINE_LEAD(0), .CW(4)
    ) dut_b (
        .clk100(clk100), .rst(rst), .en(en), .hsync(b_hs), .vsync(b_vs),
        .Pixel(b_pix), .Line(b_line), .active(b_act), .pxTick(b_tick),
        .nextLine(b_nl), .nextFrame(b_nf), .bank(b_bank)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int pack(input bit tk, input int pix, input int ln, input bit hs,
                                input bit vs, input bit act, input bit nl, input bit nf,
                                input bit bk);
        return (int'(tk) << 20) | ((pix & 63) << 14) | ((ln & 63) << 8) | (int'(hs) << 5) |
               (int'(vs) << 4) | (int'(act) << 3) | (int'(nl) << 2) | (int'(nf) << 1) | int'(bk);
    endfunction

    function automatic int pack_a();
        return pack(a_tick, int'(a_pix), int'(a_line), a_hs, a_vs, a_act, a_nl, a_nf, a_bank);
    endfunction

    function automatic int pack_b();
        return pack(b_tick, int'(b_pix), int'(b_line), b_hs, b_vs, b_act, b_nl, b_nf, b_bank);
    endfunction

    // Reference model: position is purely the number of pixel ticks since reset.
    int   m_en_cnt, m_t;
    logic m_nl, m_nf, m_bank, m_tick;

    function automatic int px_of(input int t); return t % AHT; endfunction
    function automatic int ln_of(input int t); return (t / AHT) % AVT; endfunction
    function automatic bit nl_land(input int t);
        return px_of(t) == AHT - 1 - ALL && (ln_of(t) == AVT - 1 || ln_of(t) <= AVA - 2);
    endfunction
    function automatic bit nf_land(input int t);
        return px_of(t) == 0 && ln_of(t) == AVA;
    endfunction

    assign m_tick = en && (m_en_cnt % APD == APD - 1);

    always @(posedge clk100 or posedge rst) begin
        if (rst) begin
            m_en_cnt <= 0; m_t <= 0; m_nl <= 1'b0; m_nf <= 1'b0; m_bank <= 1'b0;
        end else if (en) begin
            m_en_cnt <= m_en_cnt + 1;
            m_nl     <= m_tick && nl_land(m_t + 1);
            m_nf     <= m_tick && nf_land(m_t + 1);
            if (m_tick) begin
                m_t <= m_t + 1;
                if (nf_land(m_t + 1)) m_bank <= 1'b0;
                else if (nl_land(m_t + 1)) m_bank <= ~m_bank;
            end
        end
    end

    always @(negedge clk100) begin
        int p, l;
        bit st, hs, vs;
        if (model_on && !rst) begin
            p  = px_of(m_t);
            l  = ln_of(m_t);
            st = (m_t > 0);
            hs = (st && p >= AHA + AHF && p < AHA + AHF + AHS) ? AHP : ~AHP;
            vs = (st && l >= AVA + AVF && l < AVA + AVF + AVS) ? AVP : ~AVP;
            check("model", pack_a(),
                  pack(m_tick, p, l, hs, vs, st && p < AHA && l < AVA,
                       en && m_nl, en && m_nf, m_bank));
        end
    end

    typedef struct {
        int cyc; int pix; int ln;
        bit tk; bit hs; bit vs; bit act; bit nl; bit nf; bit bk;
    } vec_t;
    vec_t tbl[20];

    task automatic check_reset(input string tag);
        check({tag, "_a"}, pack_a(), pack(0, 0, 0, ~AHP, ~AVP, 0, 0, 0, 0));
        check({tag, "_b"}, pack_b(), pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
    endtask

    initial begin
        int cur, found, held_pix, held_line, b_bk, c_pix, c_ln;
        bit b_nl_e, b_nf_e;
        //        cyc  pix ln  tk hs vs act nl nf bk
        tbl[0]  = '{  0,  0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{  2,  0, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{  3,  1, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[3]  = '{ 30, 10, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{ 36, 12, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{ 37, 12, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{ 38, 12, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{ 39, 13, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{ 45,  0, 1, 0, 1, 0, 1, 0, 0, 1};
        tbl[9]  = '{216, 12, 4, 0, 0, 0, 0, 1, 0, 1};
        tbl[10] = '{261, 12, 5, 0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{270,  0, 6, 0, 1, 0, 0, 0, 1, 0};
        tbl[12] = '{271,  0, 6, 0, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{315,  0, 7, 0, 1, 1, 0, 0, 0, 0};
        tbl[14] = '{402, 14, 8, 0, 1, 1, 0, 0, 0, 0};
        tbl[15] = '{405,  0, 9, 0, 1, 0, 0, 0, 0, 0};
        tbl[16] = '{441, 12, 9, 0, 0, 0, 0, 1, 0, 1};
        tbl[17] = '{453,  1, 0, 0, 1, 0, 1, 0, 0, 1};
        tbl[18] = '{486, 12, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[19] = '{498,  1, 1, 0, 1, 0, 1, 0, 0, 0};

        rst = 1'b1; en = 1'b1;
        repeat (2) @(posedge clk100);
        #1 check_reset("reset_hold");

        rst = 1'b0; model_on = 1'b1;
        @(negedge clk100);
        cur = 0;
        foreach (tbl[i]) begin
            repeat (tbl[i].cyc - cur) @(negedge clk100);
            cur = tbl[i].cyc;
            check($sformatf("vec_c%0d", tbl[i].cyc), pack_a(),
                  pack(tbl[i].tk, tbl[i].pix, tbl[i].ln, tbl[i].hs, tbl[i].vs,
                       tbl[i].act, tbl[i].nl, tbl[i].nf, tbl[i].bk));
        end

        // Asynchronous mid-frame reset: values must change before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        @(posedge clk100);
        #1 check_reset("rst_edge");
        rst = 1'b0;

        // PIX_DIV=1 instance: tick every cycle, Pixel 0..6, nextLine at Pixel 6.
        b_bk = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk100);
            c_pix  = c % 7;
            c_ln   = (c / 7) % 6;
            b_nl_e = (c_pix == 6) && (c_ln == 5 || c_ln <= 1);
            b_nf_e = (c_pix == 0) && (c_ln == 3);
            if (b_nf_e) b_bk = 0;
            else if (b_nl_e) b_bk = b_bk ^ 1;
            check($sformatf("div1_c%0d", c), pack_b(),
                  pack(1, c_pix, c_ln, !(c > 0 && c_pix == 5), !(c > 0 && c_ln == 4),
                       c > 0 && c_pix < 4 && c_ln < 3, b_nl_e, b_nf_e, b_bk[0]));
        end

        // Freeze at Pixel=5 and resume: next increment must land on 6.
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(negedge clk100);
            if (a_pix == 6'd5) found = 1;
        end
        check("wait_pix5", found, 1);
        held_pix  = int'(a_pix);
        held_line = int'(a_line);
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk100);
            check("freeze", {a_tick, a_nl, a_nf, a_pix, a_line},
                  {1'b0, 1'b0, 1'b0, 6'(held_pix), 6'(held_line)});
        end
        en = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk100);
            if (int'(a_pix) != held_pix) found = 1;
        end
        check("resume_pix", int'(a_pix), held_pix + 1);

        // Random enable against the reference model, with one mid-frame reset.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk100);
            #1 en = ($urandom_range(0, 3) != 0);
            if (c == 700) begin
                #2 rst = 1'b1;
                #1 check_reset("rand_rst");
                @(posedge clk100);
                #1 rst = 1'b0;
            end
        end
        @(negedge clk100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
